// File: rtl/pipeline_stall_sequencer.sv
// pipeline_stall_sequencer: turns hazard stall/flush requests into multi-cycle PC/IF-ID/ID-EX control with perf counters
module pipeline_stall_sequencer #(
  parameter int BUBBLES_IDEX  = 2,
  parameter int BUBBLES_EXMEM = 1,
  parameter int BUBBLES_MEMWB = 1,
  parameter int CNT_W         = 2,
  parameter int PERF_W        = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Hz_StallIDEX,
  input  logic              Hz_StallEXMEM,
  input  logic              Hz_StallMEMWB,
  input  logic              Hz_Flush,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IDEX_Bubble,
  output logic              IFID_Flush,
  output logic              Stalling,
  output logic [PERF_W-1:0] StallCycles,
  output logic [15:0]       FlushCount
);
  typedef enum logic {RUN, STALL} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, n, n_a, n_b, n_c, n_ab;
  logic bubble;
  always_comb begin
    n_a = Hz_StallIDEX ? CNT_W'(BUBBLES_IDEX) : '0;
    n_b = Hz_StallEXMEM ? CNT_W'(BUBBLES_EXMEM) : '0;
    n_c = Hz_StallMEMWB ? CNT_W'(BUBBLES_MEMWB) : '0;
    n_ab = n_a > n_b ? n_a : n_b;
    n = n_ab > n_c ? n_ab : n_c;
    bubble = state == STALL || n != '0;
    PCWrite = ~bubble;
    IFIDWrite = ~bubble;
    IDEX_Bubble = bubble;
    IFID_Flush = ~bubble && Hz_Flush;
  end
  // Once latched, the remaining bubbles run down regardless of the hazard inputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= RUN;
      cnt <= '0;
      Stalling <= 1'b0;
      StallCycles <= '0;
      FlushCount <= '0;
    end else begin
      if (state == RUN) begin
        if (n > CNT_W'(1)) begin
          state <= STALL;
          cnt <= n - CNT_W'(1);
          Stalling <= 1'b1;
        end
      end else begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state <= RUN;
          Stalling <= 1'b0;
        end
      end
      if (bubble && !(&StallCycles)) StallCycles <= StallCycles + PERF_W'(1);
      if (IFID_Flush && !(&FlushCount)) FlushCount <= FlushCount + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// tb_pipeline_stall_sequencer: scenario tasks with a queue of expected per-cycle control outputs
module tb_pipeline_stall_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hz_idex = 1'b0, hz_exmem = 1'b0, hz_memwb = 1'b0, hz_flush = 1'b0;
  logic pc_write, ifid_write, idex_bubble, ifid_flush, stalling;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic s_pc_write, s_ifid_write, s_idex_bubble, s_ifid_flush, s_stalling;
  logic [2:0] s_stall_cycles;
  logic [15:0] s_flush_count;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [4:0] q[$];
  int sc_exp = 0;
  int fc_exp = 0;

  localparam logic [4:0] RUNO = 5'b11000;
  localparam logic [4:0] BUB  = 5'b00100;
  localparam logic [4:0] STL  = 5'b00101;
  localparam logic [4:0] FLS  = 5'b11010;

  always #5 clk = ~clk;

  pipeline_stall_sequencer dut (
    .Clk(clk), .Rst(rst),
    .Hz_StallIDEX(hz_idex), .Hz_StallEXMEM(hz_exmem), .Hz_StallMEMWB(hz_memwb), .Hz_Flush(hz_flush),
    .PCWrite(pc_write), .IFIDWrite(ifid_write), .IDEX_Bubble(idex_bubble), .IFID_Flush(ifid_flush),
    .Stalling(stalling), .StallCycles(stall_cycles), .FlushCount(flush_count)
  );

  pipeline_stall_sequencer #(.PERF_W(3)) u_sat (
    .Clk(clk), .Rst(rst),
    .Hz_StallIDEX(hz_idex), .Hz_StallEXMEM(hz_exmem), .Hz_StallMEMWB(hz_memwb), .Hz_Flush(hz_flush),
    .PCWrite(s_pc_write), .IFIDWrite(s_ifid_write), .IDEX_Bubble(s_idex_bubble), .IFID_Flush(s_ifid_flush),
    .Stalling(s_stalling), .StallCycles(s_stall_cycles), .FlushCount(s_flush_count)
  );

  task automatic apply(input logic [3:0] s);
    @(posedge clk);
    #1 {hz_idex, hz_exmem, hz_memwb, hz_flush} = s;
    #3;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    {hz_idex, hz_exmem, hz_memwb, hz_flush} = 4'b1111;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    {hz_idex, hz_exmem, hz_memwb, hz_flush} = 4'b0000;
    #3;
    q.push_back(RUNO);
    total_cnt++;
    if ({pc_write, ifid_write, idex_bubble, ifid_flush, stalling} !== q[0])
      $display("FAIL reset_ctl got %b exp %b", {pc_write, ifid_write, idex_bubble, ifid_flush, stalling}, q[0]);
    else pass_cnt++;
    void'(q.pop_front());
    total_cnt++;
    if (stall_cycles !== 32'd0 || flush_count !== 16'd0)
      $display("FAIL reset_counters got sc=%0d fc=%0d exp 0 0", stall_cycles, flush_count);
    else pass_cnt++;
    sc_exp = 0;
    fc_exp = 0;
  endtask

  task automatic test_lw_use();
    logic [3:0] st[3] = '{4'b1000, 4'b0000, 4'b0000};
    logic [4:0] e;
    q.push_back(BUB); q.push_back(STL); q.push_back(RUNO);
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      e = q.pop_front();
      total_cnt++;
      if ({pc_write, ifid_write, idex_bubble, ifid_flush, stalling} !== e)
        $display("FAIL lw_use cyc%0d got %b exp %b", i, {pc_write, ifid_write, idex_bubble, ifid_flush, stalling}, e);
      else pass_cnt++;
    end
    sc_exp += 2;
    total_cnt++;
    if (stall_cycles !== 32'(sc_exp)) $display("FAIL lw_use_sc got %0d exp %0d", stall_cycles, sc_exp);
    else pass_cnt++;
  endtask

  task automatic test_memwb_hold();
    logic [3:0] st[4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000};
    logic [4:0] e;
    q.push_back(BUB); q.push_back(BUB); q.push_back(BUB); q.push_back(RUNO);
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      e = q.pop_front();
      total_cnt++;
      if ({pc_write, ifid_write, idex_bubble, ifid_flush, stalling} !== e)
        $display("FAIL memwb_hold cyc%0d got %b exp %b", i, {pc_write, ifid_write, idex_bubble, ifid_flush, stalling}, e);
      else pass_cnt++;
    end
    sc_exp += 3;
    total_cnt++;
    if (stall_cycles !== 32'(sc_exp)) $display("FAIL memwb_hold_sc got %0d exp %0d", stall_cycles, sc_exp);
    else pass_cnt++;
  endtask

  task automatic test_multi();
    logic [3:0] st[3] = '{4'b1100, 4'b1100, 4'b0000};
    logic [4:0] e;
    q.push_back(BUB); q.push_back(STL); q.push_back(RUNO);
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      e = q.pop_front();
      total_cnt++;
      if ({pc_write, ifid_write, idex_bubble, ifid_flush, stalling} !== e)
        $display("FAIL multi cyc%0d got %b exp %b", i, {pc_write, ifid_write, idex_bubble, ifid_flush, stalling}, e);
      else pass_cnt++;
    end
    sc_exp += 2;
    total_cnt++;
    if (stall_cycles !== 32'(sc_exp)) $display("FAIL multi_sc got %0d exp %0d", stall_cycles, sc_exp);
    else pass_cnt++;
  endtask

  task automatic test_flush_stall();
    logic [3:0] st[4] = '{4'b1001, 4'b0001, 4'b0001, 4'b0000};
    logic [4:0] e;
    q.push_back(BUB); q.push_back(STL); q.push_back(FLS); q.push_back(RUNO);
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      e = q.pop_front();
      total_cnt++;
      if ({pc_write, ifid_write, idex_bubble, ifid_flush, stalling} !== e)
        $display("FAIL flush_stall cyc%0d got %b exp %b", i, {pc_write, ifid_write, idex_bubble, ifid_flush, stalling}, e);
      else pass_cnt++;
    end
    sc_exp += 2;
    fc_exp += 1;
    total_cnt++;
    if (stall_cycles !== 32'(sc_exp) || flush_count !== 16'(fc_exp))
      $display("FAIL flush_stall_cnt got sc=%0d fc=%0d exp sc=%0d fc=%0d", stall_cycles, flush_count, sc_exp, fc_exp);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] st[5] = '{4'b1000, 4'b0111, 4'b0100, 4'b0001, 4'b0000};
    logic [4:0] e;
    q.push_back(BUB); q.push_back(STL); q.push_back(BUB); q.push_back(FLS); q.push_back(RUNO);
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      e = q.pop_front();
      total_cnt++;
      if ({pc_write, ifid_write, idex_bubble, ifid_flush, stalling} !== e)
        $display("FAIL back_to_back cyc%0d got %b exp %b", i, {pc_write, ifid_write, idex_bubble, ifid_flush, stalling}, e);
      else pass_cnt++;
    end
    sc_exp += 3;
    fc_exp += 1;
    total_cnt++;
    if (stall_cycles !== 32'(sc_exp) || flush_count !== 16'(fc_exp))
      $display("FAIL back_to_back_cnt got sc=%0d fc=%0d exp sc=%0d fc=%0d", stall_cycles, flush_count, sc_exp, fc_exp);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    logic [4:0] e;
    q.push_back(BUB); q.push_back(STL); q.push_back(RUNO);
    apply(4'b1000);
    e = q.pop_front();
    total_cnt++;
    if ({pc_write, ifid_write, idex_bubble, ifid_flush, stalling} !== e)
      $display("FAIL rst_mid_first got %b exp %b", {pc_write, ifid_write, idex_bubble, ifid_flush, stalling}, e);
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b1;
    hz_idex = 1'b0;
    #3 e = q.pop_front();
    total_cnt++;
    if ({pc_write, ifid_write, idex_bubble, ifid_flush, stalling} !== e)
      $display("FAIL rst_mid_stall got %b exp %b", {pc_write, ifid_write, idex_bubble, ifid_flush, stalling}, e);
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    #3 e = q.pop_front();
    total_cnt++;
    if ({pc_write, ifid_write, idex_bubble, ifid_flush, stalling} !== e)
      $display("FAIL rst_mid_after got %b exp %b", {pc_write, ifid_write, idex_bubble, ifid_flush, stalling}, e);
    else pass_cnt++;
    sc_exp = 0;
    fc_exp = 0;
    total_cnt++;
    if (stall_cycles !== 32'(sc_exp) || flush_count !== 16'(fc_exp) || s_stall_cycles !== 3'd0)
      $display("FAIL rst_mid_cnt got sc=%0d fc=%0d sat=%0d exp 0 0 0", stall_cycles, flush_count, s_stall_cycles);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6; i++) apply(4'b0010);
    apply(4'b0000);
    total_cnt++;
    if (s_stall_cycles !== 3'd6) $display("FAIL sat_pre got %0d exp 6", s_stall_cycles);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) apply(4'b0010);
    apply(4'b0000);
    sc_exp += 9;
    total_cnt++;
    if (s_stall_cycles !== 3'd7) $display("FAIL sat_hold got %0d exp 7", s_stall_cycles);
    else pass_cnt++;
    total_cnt++;
    if (stall_cycles !== 32'(sc_exp)) $display("FAIL sat_main_sc got %0d exp %0d", stall_cycles, sc_exp);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lw_use();
    test_memwb_hold();
    test_multi();
    test_flush_stall();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
